// File: rtl/seq_pkg.sv
// Shared definitions for the bit-stream sequence detector slice: state encoding,
// default word width and the detected pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StPar   = 2'b10
  } seq_state_e;

  localparam int unsigned SeqWidthDefault = 8;

  localparam logic [3:0] SeqPattern = 4'b1101;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bits out.
// Optional even-parity bit after each word when SEQ_SER_PARITY_EN is defined.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SeqWidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             dout,
  output logic             bit_valid,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

  seq_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
`ifdef SEQ_SER_PARITY_EN
  logic             par_q;
`endif

  logic accept;
  assign accept = valid_in && ready_out;

  // Ready depends only on registered state so no input reaches an output.
  always_comb begin
    ready_out = 1'b0;
    case (state_q)
      StIdle:  ready_out = 1'b1;
`ifdef SEQ_SER_PARITY_EN
      StShift: ready_out = 1'b0;
      StPar:   ready_out = 1'b1;
`else
      StShift: ready_out = (cnt_q == '0);
`endif
      default: ready_out = 1'b0;
    endcase
  end

  // shift_q holds the bits still to be presented; dout is the bit on the line now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      dout      <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (accept) begin
      state_q   <= StShift;
      shift_q   <= {data_in[WIDTH-2:0], 1'b0};
      cnt_q     <= CntLoad;
      dout      <= data_in[WIDTH-1];
      bit_valid <= 1'b1;
      busy      <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
      par_q     <= ^data_in;
`endif
    end else begin
      case (state_q)
        StShift: begin
          if (cnt_q == '0) begin
`ifdef SEQ_SER_PARITY_EN
            state_q <= StPar;
            dout    <= par_q;
`else
            state_q   <= StIdle;
            dout      <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
`endif
          end else begin
            dout    <= shift_q[WIDTH-1];
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q   <= StIdle;
          dout      <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed scenarios plus random traffic
// checked against a queue-of-expected-bits model. Honors SEQ_SER_PARITY_EN.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  localparam int unsigned Width = 8;
`ifdef SEQ_SER_PARITY_EN
  localparam int unsigned WordLen = Width + 1;
`else
  localparam int unsigned WordLen = Width;
`endif

  logic             clk;
  logic             rst;
  logic [Width-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             dout;
  logic             bit_valid;
  logic             busy;

  seq_bit_serializer #(.WIDTH(Width)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .dout      (dout),
    .bit_valid (bit_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  logic last_dout, last_ready, last_bv;
  logic [3:0] window;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: exp_q holds every bit still owed to the line, head = bit showing now.
  // The block can take a word exactly when at most the current bit is outstanding.
  task automatic step(input logic v, input logic [Width-1:0] d);
    logic ready_exp;
    logic acc;
    @(negedge clk);
    ready_exp = (exp_q.size() <= 1);
    check("ready_out", {31'd0, ready_out}, {31'd0, ready_exp});
    check("dout", {31'd0, dout}, {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b0});
    check("bit_valid", {31'd0, bit_valid}, {31'd0, exp_q.size() > 0});
    check("busy", {31'd0, busy}, {31'd0, exp_q.size() > 0});
    last_dout  = dout;
    last_ready = ready_out;
    last_bv    = bit_valid;
    valid_in   = v;
    data_in    = d;
    acc        = v && ready_exp;
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      for (int i = Width - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_SER_PARITY_EN
      exp_q.push_back(^d);
`endif
    end
  endtask

  initial begin
    logic [Width-1:0] word;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, ready_out}, 32'd1);
    check("reset_dout", {31'd0, dout}, 32'd0);
    rst = 1'b0;

    // Idle line after reset release.
    repeat (5) step(1'b0, $urandom);

    // Single word D0: MSB first, pattern 1101 complete on bit 4.
    word = 8'hD0;
    step(1'b1, word);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      check("d0_bit", {31'd0, last_dout}, {31'd0, word[7-i]});
      window = {window[2:0], last_dout};
      if (i == 3) check("d0_pattern", {28'd0, window}, {28'd0, SeqPattern});
    end
`ifdef SEQ_SER_PARITY_EN
    step(1'b0, '0);
    check("d0_parity", {31'd0, last_dout}, 32'd1);
    step(1'b1, 8'hC0);
    repeat (8) step(1'b0, '0);
    step(1'b0, '0);
    check("c0_parity", {31'd0, last_dout}, 32'd0);
`endif
    repeat (2) step(1'b0, '0);

    // Back-to-back 0D then 80 with valid held high: no gap, ready only on last bits.
    step(1'b1, 8'h0D);
    for (int k = 1; k <= 2 * WordLen; k++) begin
      step(k <= WordLen, 8'h80);
      check("b2b_bv", {31'd0, last_bv}, 32'd1);
      check("b2b_ready", {31'd0, last_ready}, {31'd0, (k == WordLen) || (k == 2 * WordLen)});
    end
    step(1'b0, '0);
    check("b2b_done", {31'd0, last_bv}, 32'd0);

    // FF pulsed mid-word while not ready: ignored.
    step(1'b1, 8'h3C);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, 8'hFF);
    for (int k = 0; k < WordLen; k++) step(1'b0, $urandom);
    check("pulse_ignored", {31'd0, last_bv}, 32'd0);

    // Reset at bit 4 of B6: outputs drop immediately.
    step(1'b1, 8'hB6);
    repeat (4) step(1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_bv", {31'd0, bit_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) step($urandom_range(0, 2) != 0, $urandom);
    for (int k = 0; k < WordLen + 1; k++) step(1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
